// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_BURST = 1'b1;

   typedef enum logic [0:0] {
      IDLE  = S_IDLE,
      BURST = S_BURST
   } arb_state_t;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      CORE = 2'd1,
      HOST = 2'd2
   } arb_src_t;

   // Host bursts are word-addressed over byte-wide storage.
   localparam int WORD_STRIDE = 4;

endpackage

// File: rtl/dmem_burst_ctr.sv
// Host burst bookkeeping: latched base/length/direction, beat counter,
// wrap-around beat address and last-beat detect.
module dmem_burst_ctr
   import dmem_arb_pkg::*;
#(
   parameter int N     = 16,
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             advance,
   input  logic             start_we,
   input  logic [N-1:0]     start_addr,
   input  logic [LEN_W-1:0] start_len,
   output logic             we,
   output logic [N-1:0]     addr,
   output logic             last
);

   logic [N-1:0]     base_reg;
   logic [LEN_W-1:0] len_reg;
   logic [LEN_W-1:0] beat_reg;
   logic             we_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         base_reg <= '0;
         len_reg  <= '0;
         beat_reg <= '0;
         we_reg   <= 1'b0;
      end else if (load) begin
         base_reg <= start_addr;
         len_reg  <= start_len;
         beat_reg <= '0;
         we_reg   <= start_we;
      end else if (advance) begin
         beat_reg <= beat_reg + LEN_W'(1);
      end
   end

   // N-bit sum drops the carry, so a burst near the top wraps to address 0.
   assign addr = base_reg + N'(beat_reg) * N'(WORD_STRIDE);
   assign last = (beat_reg == len_reg);
   assign we   = we_reg;

endmodule

// File: rtl/dmem_arbiter.sv
// Core/host arbiter for the single-port data memory; core wins by default.
// Optional starvation guard for host bursts: define DMEM_ARB_STARVE_GUARD_EN.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int N            = 16,
   parameter int BITS         = 32,
   parameter int LEN_W        = 8,
   parameter int STARVE_LIMIT = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             core_req,
   input  logic             core_we,
   input  logic [N-1:0]     core_addr,
   input  logic [BITS-1:0]  core_wdata,
   output logic             core_gnt,
   output logic             core_rvalid,
   output logic [BITS-1:0]  core_rdata,
   input  logic             host_start,
   input  logic             host_we,
   input  logic [N-1:0]     host_addr,
   input  logic [LEN_W-1:0] host_len,
   input  logic [BITS-1:0]  host_wdata,
   output logic             host_busy,
   output logic             host_gnt,
   output logic             host_rvalid,
   output logic [BITS-1:0]  host_rdata,
   output logic             host_done,
   output logic             mem_we,
   output logic [N-1:0]     mem_addr,
   output logic [BITS-1:0]  mem_wdata,
   input  logic [BITS-1:0]  mem_rdata
);

   arb_state_t      state_reg, state_next;
   arb_src_t        rd_src;
   logic            start_burst, core_take, host_beat, force_host;
   logic            burst_we, burst_last;
   logic [N-1:0]    burst_addr;
   logic            core_rvalid_reg, host_rvalid_reg, host_done_reg;
   logic [BITS-1:0] core_rdata_reg, host_rdata_reg;

   assign start_burst = (state_reg == IDLE) && host_start;
   assign core_take   = core_req && !force_host;
   assign host_beat   = (state_reg == BURST) && !core_take;

`ifdef DMEM_ARB_STARVE_GUARD_EN
   localparam int SC_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT + 1) : 1;
   logic [SC_W-1:0] starve_reg;

   assign force_host = (state_reg == BURST) && (starve_reg == SC_W'(STARVE_LIMIT));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         starve_reg <= '0;
      else if (start_burst || host_beat)
         starve_reg <= '0;
      else if ((state_reg == BURST) && core_take)
         starve_reg <= starve_reg + SC_W'(1);
   end
`else
   // Keeps the guard limit referenced when the guard is compiled out.
   logic unused_limit;
   assign unused_limit = ^STARVE_LIMIT;
   assign force_host   = 1'b0;
`endif

   dmem_burst_ctr #(
      .N     (N),
      .LEN_W (LEN_W)
   ) u_burst_ctr (
      .clk        (clk),
      .rst        (rst),
      .load       (start_burst),
      .advance    (host_beat),
      .start_we   (host_we),
      .start_addr (host_addr),
      .start_len  (host_len),
      .we         (burst_we),
      .addr       (burst_addr),
      .last       (burst_last)
   );

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (host_start) state_next = BURST;
         BURST:   if (host_beat && burst_last) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Reset forces every memory-side output low, not just the write strobe.
   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
      rd_src    = NONE;
      if (rst) begin
         mem_addr  = '0;
         mem_wdata = '0;
      end else if (core_take) begin
         mem_we = core_we;
         rd_src = core_we ? NONE : CORE;
      end else if (host_beat) begin
         mem_we    = burst_we;
         mem_addr  = burst_addr;
         mem_wdata = host_wdata;
         rd_src    = burst_we ? NONE : HOST;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg       <= IDLE;
         core_rvalid_reg <= 1'b0;
         host_rvalid_reg <= 1'b0;
         host_done_reg   <= 1'b0;
         core_rdata_reg  <= '0;
         host_rdata_reg  <= '0;
      end else begin
         state_reg       <= state_next;
         core_rvalid_reg <= (rd_src == CORE);
         host_rvalid_reg <= (rd_src == HOST);
         host_done_reg   <= host_beat && burst_last;
         if (rd_src == CORE) core_rdata_reg <= mem_rdata;
         if (rd_src == HOST) host_rdata_reg <= mem_rdata;
      end
   end

   assign core_gnt    = core_take && !rst;
   assign host_gnt    = host_beat && !rst;
   assign host_busy   = (state_reg == BURST);
   assign core_rvalid = core_rvalid_reg;
   assign core_rdata  = core_rdata_reg;
   assign host_rvalid = host_rvalid_reg;
   assign host_rdata  = host_rdata_reg;
   assign host_done   = host_done_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a byte-wide memory model;
// guard expectations follow DMEM_ARB_STARVE_GUARD_EN.
module tb_dmem_arbiter;

   localparam int N     = 16;
   localparam int BITS  = 32;
   localparam int LEN_W = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             core_req, core_we;
   logic [N-1:0]     core_addr;
   logic [BITS-1:0]  core_wdata;
   logic             core_gnt, core_rvalid;
   logic [BITS-1:0]  core_rdata;
   logic             host_start, host_we;
   logic [N-1:0]     host_addr;
   logic [LEN_W-1:0] host_len;
   logic [BITS-1:0]  host_wdata;
   logic             host_busy, host_gnt, host_rvalid, host_done;
   logic [BITS-1:0]  host_rdata;
   logic             mem_we;
   logic [N-1:0]     mem_addr;
   logic [BITS-1:0]  mem_wdata, mem_rdata;

   int errors = 0;
   int checks = 0;
   logic [31:0] core_q[$];
   logic [31:0] host_q[$];

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;
   vec_t vecs[8];

   dmem_arbiter #(.N(N), .BITS(BITS), .LEN_W(LEN_W), .STARVE_LIMIT(3)) dut (
      .clk(clk), .rst(rst),
      .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
      .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
      .host_start(host_start), .host_we(host_we), .host_addr(host_addr), .host_len(host_len),
      .host_wdata(host_wdata), .host_busy(host_busy), .host_gnt(host_gnt),
      .host_rvalid(host_rvalid), .host_rdata(host_rdata), .host_done(host_done),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   logic [7:0] mem [0:65535];
   always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata[7:0];
   assign mem_rdata = {24'h0, mem[mem_addr]};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic drive_idle();
      core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
      host_start = 0; host_we = 0; host_addr = '0; host_len = '0; host_wdata = '0;
   endtask

   // Read completions: each rvalid pops the oldest expected value.
   always @(negedge clk) begin
      if (!rst) begin
         if (core_rvalid) begin
            if (core_q.size() == 0) chk("core_rvalid_unexpected", 32'd1, 32'd0);
            else begin
               $display("core read data %h", core_rdata);
               chk("core_rdata", core_rdata, core_q.pop_front());
            end
         end
         if (host_rvalid) begin
            if (host_q.size() == 0) chk("host_rvalid_unexpected", 32'd1, 32'd0);
            else begin
               $display("host read data %h", host_rdata);
               chk("host_rdata", host_rdata, host_q.pop_front());
            end
         end
      end
   end

   task automatic core_rd(input logic [15:0] a, input logic [31:0] exp);
      next_cycle();
      drive_idle();
      core_req = 1; core_addr = a;
      core_q.push_back(exp);
      settle();
      chk("core_rd_gnt", core_gnt, 1);
   endtask

   task automatic host_burst(input logic we, input logic [15:0] base, input logic [7:0] len,
                             input logic [31:0] d0);
      logic [15:0] ea;
      next_cycle();
      drive_idle();
      host_start = 1; host_we = we; host_addr = base; host_len = len;
      settle();
      chk("start_no_gnt", host_gnt, 0);
      chk("start_not_busy", host_busy, 0);
      for (int b = 0; b <= int'(len); b++) begin
         next_cycle();
         // Scramble the start fields to prove they were latched.
         host_start = 0; host_we = ~we; host_addr = 16'h5A5A; host_len = 8'hFF;
         host_wdata = d0 + 32'(b);
         ea = base + 16'(4 * b);
         if (!we) host_q.push_back(d0 + 32'(b));
         settle();
         $display("host beat %0d addr %h we %0d", b, mem_addr, mem_we);
         chk("burst_gnt", host_gnt, 1);
         chk("burst_busy", host_busy, 1);
         chk("burst_addr", mem_addr, ea);
         chk("burst_we", mem_we, we);
         chk("burst_no_done", host_done, 0);
      end
      next_cycle();
      drive_idle();
      settle();
      chk("burst_done", host_done, 1);
      chk("burst_busy_fall", host_busy, 0);
      chk("burst_end_no_gnt", host_gnt, 0);
      next_cycle();
      settle();
      chk("burst_done_pulse", host_done, 0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic       exp_h, exp_c, exp_done;
      int         beats, k, hb;
      logic [15:0] ea;

      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      vecs[0] = '{1'b1, 16'h0010, 32'h000000A5, 32'h0};
      vecs[1] = '{1'b0, 16'h0010, 32'h0,        32'h000000A5};
      vecs[2] = '{1'b1, 16'h0011, 32'h1234563C, 32'h0};
      vecs[3] = '{1'b0, 16'h0011, 32'h0,        32'h0000003C};
      vecs[4] = '{1'b0, 16'h0010, 32'h0,        32'h000000A5};
      vecs[5] = '{1'b1, 16'hFFFF, 32'hFFFFFF7E, 32'h0};
      vecs[6] = '{1'b0, 16'hFFFF, 32'h0,        32'h0000007E};
      vecs[7] = '{1'b0, 16'h0020, 32'h0,        32'h00000000};

      // Reset state, with live core inputs that must not leak through.
      rst = 1;
      drive_idle();
      core_req = 1; core_we = 1; core_addr = 16'h1234; core_wdata = 32'hDEADBEEF;
      #2;
      chk("rst_core_gnt", core_gnt, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_busy", host_busy, 0);
      chk("rst_core_rvalid", core_rvalid, 0);
      chk("rst_core_rdata", core_rdata, 0);
      chk("rst_host_done", host_done, 0);
      next_cycle();
      next_cycle();
      rst = 0;
      drive_idle();

      // Core-only single-beat table.
      for (int i = 0; i < 8; i++) begin
         next_cycle();
         drive_idle();
         core_req = 1; core_we = vecs[i].we; core_addr = vecs[i].addr; core_wdata = vecs[i].wdata;
         if (!vecs[i].we) core_q.push_back(vecs[i].exp);
         settle();
         $display("core %s addr %h", vecs[i].we ? "wr" : "rd", vecs[i].addr);
         chk("vec_core_gnt", core_gnt, 1);
         chk("vec_host_gnt", host_gnt, 0);
         chk("vec_mem_we", mem_we, vecs[i].we);
         chk("vec_mem_addr", mem_addr, vecs[i].addr);
      end

      // Host write burst, then read it back through the core.
      host_burst(1'b1, 16'h0100, 8'd3, 32'd1);
      for (int i = 0; i < 4; i++) core_rd(16'h0100 + 16'(4 * i), 32'(i + 1));

      // Contention: core reads every other cycle during a 4-beat host read.
      next_cycle();
      drive_idle();
      host_start = 1; host_we = 0; host_addr = 16'h0100; host_len = 8'd3;
      settle();
      beats = 0; k = 0;
      while (beats < 4 && k < 20) begin
         next_cycle();
         drive_idle();
         core_req = (k % 2 == 0); core_addr = 16'h0010;
         if (core_req) begin
            core_q.push_back(32'hA5);
            settle();
            chk("cont_core_gnt", core_gnt, 1);
            chk("cont_host_held", host_gnt, 0);
         end else begin
            host_q.push_back(32'(beats + 1));
            ea = 16'h0100 + 16'(4 * beats);
            settle();
            chk("cont_host_gnt", host_gnt, 1);
            chk("cont_core_idle", core_gnt, 0);
            chk("cont_addr", mem_addr, ea);
            beats++;
         end
         k++;
      end
      next_cycle();
      drive_idle();
      settle();
      chk("cont_done", host_done, 1);
      chk("cont_busy_fall", host_busy, 0);

      // Wrap at the top of memory.
      host_burst(1'b1, 16'hFFFC, 8'd1, 32'h11);
      core_rd(16'hFFFC, 32'h11);
      core_rd(16'h0000, 32'h12);

      // Core held high through a 2-beat host read; start shares a core cycle.
      next_cycle();
      drive_idle();
      host_start = 1; host_we = 0; host_addr = 16'h0100; host_len = 8'd1;
      core_req = 1; core_addr = 16'h0010;
      core_q.push_back(32'hA5);
      settle();
      chk("guard_start_core_gnt", core_gnt, 1);
      chk("guard_start_host_gnt", host_gnt, 0);
      hb = 0;
      for (int j = 0; j < 11; j++) begin
         next_cycle();
         drive_idle();
         core_req = (j < 8); core_addr = 16'h0010;
`ifdef DMEM_ARB_STARVE_GUARD_EN
         exp_h = (j == 3 || j == 7);
         exp_done = (j == 8);
`else
         exp_h = (j == 8 || j == 9);
         exp_done = (j == 10);
`endif
         exp_c = core_req && !exp_h;
         if (exp_c) core_q.push_back(32'hA5);
         if (exp_h) begin
            host_q.push_back(32'(hb + 1));
            hb++;
         end
         settle();
         chk("guard_core_gnt", core_gnt, exp_c);
         chk("guard_host_gnt", host_gnt, exp_h);
         chk("guard_done", host_done, exp_done);
      end

      // Reset after beat 1 of a write burst.
      next_cycle();
      drive_idle();
      host_start = 1; host_we = 1; host_addr = 16'h0200; host_len = 8'd3;
      settle();
      next_cycle();
      host_start = 0; host_wdata = 32'h55;
      settle();
      chk("rb_beat0", host_gnt, 1);
      next_cycle();
      host_wdata = 32'h66;
      settle();
      chk("rb_beat1", host_gnt, 1);
      next_cycle();
      rst = 1;
      core_req = 1; core_we = 1; core_addr = 16'h0030; core_wdata = 32'hAA; host_wdata = 32'h77;
      #1;
      chk("rb_core_gnt", core_gnt, 0);
      chk("rb_host_gnt", host_gnt, 0);
      chk("rb_busy", host_busy, 0);
      chk("rb_done", host_done, 0);
      chk("rb_mem_we", mem_we, 0);
      chk("rb_mem_addr", mem_addr, 0);
      chk("rb_mem_wdata", mem_wdata, 0);
      chk("rb_host_rvalid", host_rvalid, 0);
      chk("rb_host_rdata", host_rdata, 0);
      chk("rb_core_rdata", core_rdata, 0);
      next_cycle();
      rst = 0;
      drive_idle();
      settle();
      chk("rb_post_busy", host_busy, 0);
      chk("rb_post_done", host_done, 0);
      next_cycle();
      settle();
      chk("rb_post_done2", host_done, 0);
      core_rd(16'h0200, 32'h55);
      core_rd(16'h0204, 32'h66);
      core_rd(16'h0208, 32'h00);
      core_rd(16'h0030, 32'h00);
      host_burst(1'b1, 16'h0300, 8'd0, 32'h99);
      core_rd(16'h0300, 32'h99);

      next_cycle();
      drive_idle();
      settle();
      settle();
      chk("core_q_drained", core_q.size(), 0);
      chk("host_q_drained", host_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester controller that shares the single-port byte-wide `data_memory` between the pipeline memory stage (core) and a host/loader port that moves key and ciphertext blocks in word-addressed bursts. Core accesses are single-beat and take priority. Host accesses run as bursts tracked by an internal state machine. The block drives the memory port combinationally and returns read data registered, one cycle later, to whichever requester issued the read.

## Interface
- `N`, 16: address width.
- `BITS`, 32: data width. The memory stores `[7:0]` and returns the byte zero-extended.
- `LEN_W`, 8: width of the host burst-length field.
- `STARVE_LIMIT`, 8: consecutive preempted host cycles before the host is forced through. Used only with the macro in Configuration.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `core_req`  in  1  core access request, held until granted.
- `core_we`  in  1  1 = write, 0 = read.
- `core_addr`  in  N  byte address.
- `core_wdata`  in  BITS  write data.
- `core_gnt`  out  1  access performed this cycle.
- `core_rvalid`  out  1  `core_rdata` valid.
- `core_rdata`  out  BITS  registered read data.
- `host_start`  in  1  burst start, sampled only in IDLE.
- `host_we`  in  1  burst direction, latched at start.
- `host_addr`  in  N  burst base address, latched at start.
- `host_len`  in  LEN_W  number of beats minus one, latched at start.
- `host_wdata`  in  BITS  write data, consumed on `host_gnt`.
- `host_busy`  out  1  burst in progress.
- `host_gnt`  out  1  one beat performed this cycle.
- `host_rvalid`  out  1  `host_rdata` valid.
- `host_rdata`  out  BITS  registered read data.
- `host_done`  out  1  one-cycle pulse, registered, the cycle after the last beat.
- `mem_we`  out  1  to `data_memory` `write_enable`.
- `mem_addr`  out  N  to `data_memory` `address`.
- `mem_wdata`  out  BITS  to `data_memory` `write_data`.
- `mem_rdata`  in  BITS  from `data_memory` `read_data`, combinational.

## Operation
- States are IDLE and BURST.
- IDLE → BURST on `host_start`.
  - Latch `host_we`, `host_addr`, and `host_len`.
  - Clear `beat` to 0.
- In BURST, a host beat occurs in any cycle where `core_req` = 0.
  - Beat address = base + 4·`beat`, computed mod 2^N so it wraps at the top of memory.
  - `host_gnt` = 1 for that beat.
  - `beat` increments after each beat.
- BURST → IDLE after the beat where `beat` == `host_len`. `host_done` pulses on the next cycle.
- Core has priority. `core_gnt` = `core_req`, subject to the forced host beat under the macro.
- A `host_start` in the same cycle as `core_req` still starts the burst. The core takes that cycle, and the first host beat waits.
- `host_start` while in BURST is ignored.
- Mux rules:
  - When no access is granted, `mem_we` = 0 and `mem_addr` / `mem_wdata` hold the core values.
  - `mem_we` is asserted only together with a grant.
- Read data: `mem_rdata` is captured into the granted requester's `*_rdata`, and its `*_rvalid` pulses the next cycle. The other requester's `rdata` holds its value.
- Reset, including mid-burst, aborts the burst with no `host_done` and returns to IDLE.
- Reset value of every output is 0: gnts, rvalids, rdata, `host_busy`, `host_done`, and all `mem_*` outputs.

## Timing
- Grant is combinational in the request cycle.
- Writes commit at the rising edge that ends the grant cycle.
- Read latency is 1 cycle: request in cycle t, `*_rvalid` in t+1.
- A read of the address written in cycle t returns the new byte from t+1.
- `host_busy` rises the cycle after `host_start` and falls the cycle after the last beat, together with `host_done`.
- Minimum burst duration is `host_len`+1 cycles.

## Configuration
- Macro: `DMEM_ARB_STARVE_GUARD_EN`.
- With the macro defined:
  - A counter increments on each BURST cycle in which the core takes the port, and clears on every host beat.
  - When the counter reaches `STARVE_LIMIT`, the next cycle is a forced host beat: `core_gnt` = 0 even if `core_req` = 1.
- Without the macro, the core always wins, the counter is absent, and `STARVE_LIMIT` is unused.

## Structure
- Package `dmem_arb_pkg`:
  - State enum `arb_state_t` (IDLE, BURST).
  - Requester enum `arb_src_t` (NONE, CORE, HOST), used to steer the read-data register.
  - Byte-stride constant `WORD_STRIDE` = 4.
- Sub-module `dmem_burst_ctr` holds the base and length latch, the beat counter, the wrap-around address, and last-beat detect.
- The top level holds the FSM, priority mux, read-data steering, and starvation counter.

## Test plan
- Core only: write 0xA5 to 0x0010, then read 0x0010 → `core_gnt` both cycles, `core_rvalid` next cycle, `core_rdata` = 0x000000A5.
- Host write burst: `host_addr` = 0x0100, `host_len` = 3, wdata 1..4, no core traffic → 4 consecutive `host_gnt` at 0x0100/0x0104/0x0108/0x010C, then `host_done` one cycle, then `host_busy` = 0.
- Contention: core reads every other cycle during a 4-beat host read → beats only in core-idle cycles, rdata routed to the correct port, no lost beats.
- Wrap: `host_addr` = 0xFFFC, `host_len` = 1 → beat addresses 0xFFFC then 0x0000.
- Guard, with `STARVE_LIMIT` = 3 and `core_req` held high in BURST:
  - Macro defined → forced host beat every 4th cycle, with `core_gnt` = 0 that cycle.
  - Macro undefined → no host beat until `core_req` drops.
- Reset asserted mid-burst after beat 1 → all outputs 0 immediately, IDLE, no `host_done`, and a new `host_start` is accepted after release.
